// File: rtl/game_controller.sv
// Number-guessing game sequencer: arms the countdown timer, deals LFSR targets,
// scores submitted guesses, holds feedback LEDs and tracks the best score.
module game_controller #(
    parameter int          INIT_TIME = 20,
    parameter int          MAX_SCORE = 99,
    parameter int          FB_CYCLES = 50000000,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_submit,
    input  logic [7:0] switches,
    input  logic [5:0] time_remaining,
    input  logic       game_end,
    output logic       timer_rst,
    output logic [7:0] target,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic       playing,
    output logic       led_correct,
    output logic       led_wrong,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        PLAY     = 3'd2,
        FEEDBACK = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int               FB_W    = (FB_CYCLES > 1) ? $clog2(FB_CYCLES) : 1;
    localparam logic [FB_W-1:0]  FB_LAST = FB_W'(FB_CYCLES - 1);
    localparam logic [7:0]       MAX_S   = 8'(MAX_SCORE);
    localparam logic [5:0]       INIT_T  = 6'(INIT_TIME);

    state_t            state_reg, state_next;
    logic [7:0]        lfsr_reg, lfsr_next;
    logic [7:0]        target_reg, target_next;
    logic [7:0]        score_reg, score_next;
    logic [7:0]        high_score_reg, high_score_next;
    logic              timer_rst_reg, timer_rst_next;
    logic              playing_reg, playing_next;
    logic              led_correct_reg, led_correct_next;
    logic              led_wrong_reg, led_wrong_next;
    logic [FB_W-1:0]   fb_cnt_reg, fb_cnt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            lfsr_reg        <= LFSR_SEED;
            target_reg      <= 8'd0;
            score_reg       <= 8'd0;
            high_score_reg  <= 8'd0;
            timer_rst_reg   <= 1'b1;
            playing_reg     <= 1'b0;
            led_correct_reg <= 1'b0;
            led_wrong_reg   <= 1'b0;
            fb_cnt_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            lfsr_reg        <= lfsr_next;
            target_reg      <= target_next;
            score_reg       <= score_next;
            high_score_reg  <= high_score_next;
            timer_rst_reg   <= timer_rst_next;
            playing_reg     <= playing_next;
            led_correct_reg <= led_correct_next;
            led_wrong_reg   <= led_wrong_next;
            fb_cnt_reg      <= fb_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        target_next      = target_reg;
        score_next       = score_reg;
        high_score_next  = high_score_reg;
        led_correct_next = led_correct_reg;
        led_wrong_next   = led_wrong_reg;
        fb_cnt_next      = fb_cnt_reg;

        // Right-shifting Galois form of x^8+x^6+x^5+x^4+1; a nonzero seed never reaches 0
        lfsr_next = {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? 8'hB8 : 8'h00);

        case (state_reg)
            IDLE: begin
                if (btn_start) begin
                    state_next = ARM;
                    score_next = 8'd0;
                end
            end
            ARM: begin
                score_next = 8'd0;
                if (time_remaining == INIT_T && !game_end) begin
                    state_next  = PLAY;
                    target_next = lfsr_reg;
                end
            end
            PLAY: begin
                if (game_end) begin
                    state_next       = DONE;
                    led_correct_next = 1'b0;
                    led_wrong_next   = 1'b0;
                end else if (btn_submit) begin
                    state_next  = FEEDBACK;
                    fb_cnt_next = '0;
                    if (switches == target_reg) begin
                        score_next       = (score_reg >= MAX_S) ? MAX_S : score_reg + 8'd1;
                        target_next      = lfsr_reg;
                        led_correct_next = 1'b1;
                        led_wrong_next   = 1'b0;
                    end else begin
                        led_correct_next = 1'b0;
                        led_wrong_next   = 1'b1;
                    end
                end
            end
            FEEDBACK: begin
                if (game_end) begin
                    state_next       = DONE;
                    led_correct_next = 1'b0;
                    led_wrong_next   = 1'b0;
                end else if (fb_cnt_reg == FB_LAST) begin
                    state_next       = PLAY;
                    led_correct_next = 1'b0;
                    led_wrong_next   = 1'b0;
                end else begin
                    fb_cnt_next = fb_cnt_reg + FB_W'(1);
                end
            end
            DONE: begin
                if (btn_start) begin
                    state_next = ARM;
                    score_next = 8'd0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Score never changes on the edge into DONE, so the current score is final
        if (state_next == DONE && state_reg != DONE && score_reg > high_score_reg)
            high_score_next = score_reg;

        timer_rst_next = (state_next == IDLE) || (state_next == ARM);
        playing_next   = (state_next == PLAY) || (state_next == FEEDBACK);
    end

    assign state       = state_reg;
    assign timer_rst   = timer_rst_reg;
    assign target      = target_reg;
    assign score       = score_reg;
    assign high_score  = high_score_reg;
    assign playing     = playing_reg;
    assign led_correct = led_correct_reg;
    assign led_wrong   = led_wrong_reg;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: stimulus queues the expected output
// snapshot for every output change, a negedge monitor pops and compares.
module tb_game_controller;

    localparam int         INIT_TIME = 20;
    localparam int         MAX_SCORE = 99;
    localparam int         FB_CYCLES = 4;
    localparam logic [7:0] SEED      = 8'hA5;

    localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_PLAY = 3'd2,
                           S_FB = 3'd3, S_DONE = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_submit = 1'b0;
    logic       game_end = 1'b0;
    logic [7:0] switches = 8'd0;
    logic [5:0] time_remaining = 6'd0;

    logic       timer_rst, playing, led_correct, led_wrong;
    logic [7:0] target, score, high_score;
    logic [2:0] state;

    always #5 clk = ~clk;

    game_controller #(
        .INIT_TIME (INIT_TIME),
        .MAX_SCORE (MAX_SCORE),
        .FB_CYCLES (FB_CYCLES),
        .LFSR_SEED (SEED)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start      (btn_start),
        .btn_submit     (btn_submit),
        .switches       (switches),
        .time_remaining (time_remaining),
        .game_end       (game_end),
        .timer_rst      (timer_rst),
        .target         (target),
        .score          (score),
        .high_score     (high_score),
        .playing        (playing),
        .led_correct    (led_correct),
        .led_wrong      (led_wrong),
        .state          (state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       tr;
        logic [7:0] tgt;
        logic [7:0] sc;
        logic [7:0] hi;
        logic       pl;
        logic       lc;
        logic       lw;
    } obs_t;

    typedef struct {
        string name;
        int    gap;
        obs_t  o;
    } rec_t;

    rec_t  q[$];
    obs_t  m;
    int    checks = 0;
    int    failures = 0;

    // Reference sequence for x^8+x^6+x^5+x^4+1, advanced once per clock
    logic [7:0] lfsr_m;
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic [7:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 8'hB8;
        return r;
    endfunction
    always @(posedge clk or negedge rst)
        if (!rst) lfsr_m <= SEED;
        else      lfsr_m <= lfsr_step(lfsr_m);

    // Monitor: every change of the output vector is one transaction
    obs_t prev_o, cur_o;
    rec_t r;
    int   gap = 0;
    always @(negedge clk) begin
        cur_o = '{st: state, tr: timer_rst, tgt: target, sc: score, hi: high_score,
                  pl: playing, lc: led_correct, lw: led_wrong};
        gap = gap + 1;
        if (cur_o !== prev_o) begin
            checks = checks + 1;
            if (q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_change: got st=%0d tr=%0b tgt=%02h sc=%0d hi=%0d pl=%0b lc=%0b lw=%0b, expected no change",
                         cur_o.st, cur_o.tr, cur_o.tgt, cur_o.sc, cur_o.hi, cur_o.pl, cur_o.lc, cur_o.lw);
            end else begin
                r = q.pop_front();
                if (cur_o !== r.o || (r.gap >= 0 && gap != r.gap)) begin
                    failures = failures + 1;
                    $display("FAIL %s: got st=%0d tr=%0b tgt=%02h sc=%0d hi=%0d pl=%0b lc=%0b lw=%0b gap=%0d, expected st=%0d tr=%0b tgt=%02h sc=%0d hi=%0d pl=%0b lc=%0b lw=%0b gap=%0d",
                             r.name, cur_o.st, cur_o.tr, cur_o.tgt, cur_o.sc, cur_o.hi, cur_o.pl, cur_o.lc, cur_o.lw, gap,
                             r.o.st, r.o.tr, r.o.tgt, r.o.sc, r.o.hi, r.o.pl, r.o.lc, r.o.lw, r.gap);
                end else begin
                    $display("txn %s: st=%0d tgt=%02h sc=%0d hi=%0d lc=%0b lw=%0b gap=%0d",
                             r.name, cur_o.st, cur_o.tgt, cur_o.sc, cur_o.hi, cur_o.lc, cur_o.lw, gap);
                end
            end
            gap = 0;
        end
        prev_o = cur_o;
    end

    task automatic push(input string name, input int g);
        rec_t x;
        x.name = name;
        x.gap  = g;
        x.o    = m;
        q.push_back(x);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_reset_model();
        m = '0;
        m.st = S_IDLE;
        m.tr = 1'b1;
    endtask

    task automatic press_start(input string name);
        btn_start = 1'b1;
        m.st = S_ARM; m.tr = 1'b1; m.pl = 1'b0; m.sc = 8'd0;
        push(name, -1);
        cyc(1);
        btn_start = 1'b0;
    endtask

    task automatic arm_to_play(input string name, input int g);
        time_remaining = 6'(INIT_TIME);
        m.st = S_PLAY; m.tr = 1'b0; m.pl = 1'b1; m.tgt = lfsr_m;
        push(name, g);
        cyc(1);
    endtask

    task automatic submit(input bit correct, input string name);
        switches = correct ? m.tgt : (m.tgt ^ 8'h01);
        btn_submit = 1'b1;
        m.st = S_FB;
        if (correct) begin
            if (m.sc < 8'(MAX_SCORE)) m.sc = m.sc + 8'd1;
            m.tgt = lfsr_m;
            m.lc = 1'b1;
        end else begin
            m.lw = 1'b1;
        end
        push(name, -1);
        cyc(1);
        btn_submit = 1'b0;
    endtask

    // A matching guess submitted mid-feedback must have no effect
    task automatic finish_feedback();
        switches = m.tgt;
        btn_submit = 1'b1;
        m.st = S_PLAY; m.lc = 1'b0; m.lw = 1'b0;
        push("feedback_to_play", FB_CYCLES);
        cyc(1);
        btn_submit = 1'b0;
        cyc(FB_CYCLES - 1);
    endtask

    initial begin
        set_reset_model();
        push("reset_state", -1);
        #1 rst = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(2);

        // Start with the timer not yet loaded: ARM must hold
        press_start("idle_to_arm");
        cyc(3);
        arm_to_play("arm_to_play", 4);

        // Stray start in PLAY is ignored
        btn_start = 1'b1;
        cyc(1);
        btn_start = 1'b0;

        submit(1'b1, "correct_first");
        finish_feedback();
        submit(1'b0, "wrong_guess");
        finish_feedback();

        while (m.sc < 8'(MAX_SCORE)) begin
            submit(1'b1, "correct_climb");
            finish_feedback();
        end
        submit(1'b1, "correct_saturated");
        finish_feedback();

        // game_end beats a same-cycle correct submit
        switches = m.tgt;
        btn_submit = 1'b1;
        game_end = 1'b1;
        m.st = S_DONE; m.tr = 1'b0; m.pl = 1'b0; m.lc = 1'b0; m.lw = 1'b0;
        if (m.sc > m.hi) m.hi = m.sc;
        push("end_beats_submit", -1);
        cyc(1);
        btn_submit = 1'b0;
        game_end = 1'b0;
        cyc(2);

        press_start("done_to_arm");
        arm_to_play("rearm_to_play", 1);
        submit(1'b1, "correct_game2");

        // game_end during FEEDBACK, lower score leaves high_score alone
        game_end = 1'b1;
        m.st = S_DONE; m.tr = 1'b0; m.pl = 1'b0; m.lc = 1'b0; m.lw = 1'b0;
        if (m.sc > m.hi) m.hi = m.sc;
        push("end_in_feedback", 1);
        cyc(1);
        game_end = 1'b0;
        cyc(2);

        press_start("done_to_arm_2");
        arm_to_play("rearm_to_play_2", 1);
        submit(1'b1, "correct_game3");

        // Asynchronous reset two cycles into FEEDBACK
        @(posedge clk);
        @(posedge clk);
        #2;
        set_reset_model();
        push("reset_mid_feedback", 2);
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(4);

        checks = checks + 1;
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL queue_drained: got %0d pending, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        failures = failures + 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL have parameter INIT_TIME, default 20, the timer load value awaited in ARM.
REQ-002 The block SHALL have parameter MAX_SCORE, default 99, the score saturation value.
REQ-003 The block SHALL have parameter FB_CYCLES, default 50000000, the FEEDBACK hold length in clk cycles.
REQ-004 The block SHALL have parameter LFSR_SEED, default 8'hA5, the nonzero LFSR reset value.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port btn_start, input, 1 bit: one-cycle start pulse, debounced upstream.
REQ-008 The block SHALL have port btn_submit, input, 1 bit: one-cycle submit pulse, debounced upstream.
REQ-009 The block SHALL have port switches, input, 8 bits: the player's binary guess.
REQ-010 The block SHALL have port time_remaining, input, 6 bits: the countdown timer value, synchronous to clk.
REQ-011 The block SHALL have port game_end, input, 1 bit: timer expired, synchronous to clk.
REQ-012 The block SHALL have port timer_rst, output, 1 bit: active-high reload request to the timer.
REQ-013 The block SHALL have port target, output, 8 bits: the number the player must match.
REQ-014 The block SHALL have port score, output, 8 bits: the current game score.
REQ-015 The block SHALL have port high_score, output, 8 bits: the best score since reset.
REQ-016 The block SHALL have port playing, output, 1 bit: high in PLAY or FEEDBACK.
REQ-017 The block SHALL have ports led_correct and led_wrong, outputs, 1 bit each: held high throughout FEEDBACK to show the last submit result.
REQ-018 The block SHALL have port state, output, 3 bits: encoding IDLE=0, ARM=1, PLAY=2, FEEDBACK=3, DONE=4.

Function
REQ-019 The block SHALL advance an 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) every clk cycle in all states; the LFSR value SHALL never be 0.
REQ-020 In IDLE, timer_rst SHALL be 1; on btn_start the block SHALL go to ARM.
REQ-021 In ARM, timer_rst SHALL be 1 and score SHALL be 0; when time_remaining==INIT_TIME and game_end==0, the block SHALL load target from the LFSR and go to PLAY in the same cycle.
REQ-022 In PLAY and FEEDBACK, timer_rst SHALL be 0.
REQ-023 In PLAY, on btn_submit with switches==target, the block SHALL increment score, saturating at MAX_SCORE, reload target from the LFSR, set led_correct, and go to FEEDBACK.
REQ-024 In PLAY, on btn_submit with switches!=target, the block SHALL leave score and target unchanged, set led_wrong, and go to FEEDBACK.
REQ-025 FEEDBACK SHALL last exactly FB_CYCLES cycles and then return to PLAY, clearing led_correct and led_wrong; btn_submit SHALL be ignored during FEEDBACK.
REQ-026 If game_end==1 in PLAY or FEEDBACK, the block SHALL go to DONE and clear the LEDs; game_end SHALL take priority over a same-cycle btn_submit, so that submit has no effect.
REQ-027 On entry to DONE, if score>high_score, high_score SHALL take the value of score in that cycle; otherwise high_score SHALL be unchanged.
REQ-028 In DONE, timer_rst SHALL be 0, score and target SHALL hold, and btn_start SHALL go to ARM.
REQ-029 btn_start SHALL be ignored in ARM, PLAY and FEEDBACK.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 While rst==0, the block SHALL asynchronously force state=IDLE, the LFSR to LFSR_SEED, target=0, score=0, high_score=0, timer_rst=1, and playing, led_correct, led_wrong and the FEEDBACK counter to 0.
REQ-032 Reset asserted in any state, including mid-FEEDBACK, SHALL take effect immediately; after release the block SHALL resume from IDLE at the first clk edge.

Verification
REQ-033 Reset, then btn_start with time_remaining=20 and game_end=0 -> state IDLE->ARM->PLAY; timer_rst falls on PLAY entry; target equals the LFSR value at that edge.
REQ-034 In PLAY, set switches=target and pulse btn_submit -> score 0->1, led_correct=1 for FB_CYCLES cycles, new target, then back to PLAY; with switches=target^1 -> led_wrong=1 and score unchanged.
REQ-035 Start at score=MAX_SCORE=99 and submit correctly -> score stays 99.
REQ-036 Assert game_end in the same cycle as a correct btn_submit -> DONE, score unchanged, high_score updated to score if greater.
REQ-037 In ARM, hold time_remaining=0 -> stays in ARM with timer_rst=1; then set time_remaining=20 -> PLAY.
REQ-038 Pull rst low mid-FEEDBACK -> all outputs take their reset values immediately; high_score=0.
